// File: rtl/ibfu_pipe.sv
// ibfu_pipe: pipelined inverse (DIF) radix-2 butterfly for the IFFT path.
//   out_a = (A + B) * s
//   out_b = (A - B) * conj(W) * s,   s = 1/2 when in_scale = 1, else 1
// Three register stages (sum/difference, complex product, shift+saturate),
// valid/ready on both sides, one result per clock when downstream is ready.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_a, in_b, in_w      operands, {real[2*DW-1:DW], imag[DW-1:0]}, Q1.(DW-1)
//   in_scale              1: halve both outputs
//   in_last               frame tag, travels with its operands
//   out_valid / out_ready output handshake
//   out_a, out_b          results, same packing as the operands
//   out_last              in_last of the presented result
//   sat_flag              sticky, set when any saturated component is loaded
//   sat_clr               synchronous clear of sat_flag (a new saturation wins)
//
// Build option
//   IBFU_ROUND_EN  when defined, every non-zero shift rounds half up instead of
//                  truncating toward minus infinity.

module ibfu_pipe #(
    parameter int DW     = 16,
    parameter int STAGES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] in_a,
    input  logic [2*DW-1:0] in_b,
    input  logic [2*DW-1:0] in_w,
    input  logic            in_scale,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_a,
    output logic [2*DW-1:0] out_b,
    output logic            out_last,
    output logic            sat_flag,
    input  logic            sat_clr
);

    localparam int SW = DW + 1;      // sum/difference component width
    localparam int PW = 2 * DW + 2;  // exact complex-product component width

    generate
        if (STAGES != 3) begin : g_bad_stages
            $error("ibfu_pipe: STAGES must be 3");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stall chain: a stage loads when it is empty or its content moves on.
    // ------------------------------------------------------------------
    logic v1, v2;
    logic en1, en2, en3;

    assign en3      = !out_valid || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    // ------------------------------------------------------------------
    // Stage 1: sum and difference, one guard bit so no overflow is possible
    // ------------------------------------------------------------------
    logic signed [SW-1:0] a_re, a_im, b_re, b_im;

    assign a_re = {in_a[2*DW-1], in_a[2*DW-1:DW]};
    assign a_im = {in_a[DW-1],   in_a[DW-1:0]};
    assign b_re = {in_b[2*DW-1], in_b[2*DW-1:DW]};
    assign b_im = {in_b[DW-1],   in_b[DW-1:0]};

    logic signed [SW-1:0] s1_sum_re, s1_sum_im, s1_dif_re, s1_dif_im;
    logic [2*DW-1:0]      s1_w;
    logic                 s1_scale, s1_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1        <= 1'b0;
            s1_sum_re <= '0;
            s1_sum_im <= '0;
            s1_dif_re <= '0;
            s1_dif_im <= '0;
            s1_w      <= '0;
            s1_scale  <= 1'b0;
            s1_last   <= 1'b0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sum_re <= a_re + b_re;
                s1_sum_im <= a_im + b_im;
                s1_dif_re <= a_re - b_re;
                s1_dif_im <= a_im - b_im;
                s1_w      <= in_w;
                s1_scale  <= in_scale;
                s1_last   <= in_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: dif * conj(W), full precision
    // ------------------------------------------------------------------
    logic signed [PW-1:0] dr_x, di_x, wr_x, wi_x, pr_c, pi_c;

    assign dr_x = {{(PW-SW){s1_dif_re[SW-1]}}, s1_dif_re};
    assign di_x = {{(PW-SW){s1_dif_im[SW-1]}}, s1_dif_im};
    assign wr_x = {{(PW-DW){s1_w[2*DW-1]}}, s1_w[2*DW-1:DW]};
    assign wi_x = {{(PW-DW){s1_w[DW-1]}}, s1_w[DW-1:0]};

    // conj(W) flips the sign of wi, hence the +/- pattern
    assign pr_c = dr_x * wr_x + di_x * wi_x;
    assign pi_c = di_x * wr_x - dr_x * wi_x;

    logic signed [SW-1:0] s2_sum_re, s2_sum_im;
    logic signed [PW-1:0] s2_pr, s2_pi;
    logic                 s2_scale, s2_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2        <= 1'b0;
            s2_sum_re <= '0;
            s2_sum_im <= '0;
            s2_pr     <= '0;
            s2_pi     <= '0;
            s2_scale  <= 1'b0;
            s2_last   <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                s2_sum_re <= s1_sum_re;
                s2_sum_im <= s1_sum_im;
                s2_pr     <= pr_c;
                s2_pi     <= pi_c;
                s2_scale  <= s1_scale;
                s2_last   <= s1_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: shift back to Q1.(DW-1), then symmetric saturation
    // ------------------------------------------------------------------
    logic signed [PW-1:0] sr_x, si_x;
    logic signed [PW-1:0] sr_r, si_r, pr_r, pi_r;
    logic signed [PW-1:0] sr_sh, si_sh, pr_sh, pi_sh;

    assign sr_x = {{(PW-SW){s2_sum_re[SW-1]}}, s2_sum_re};
    assign si_x = {{(PW-SW){s2_sum_im[SW-1]}}, s2_sum_im};

`ifdef IBFU_ROUND_EN
    // Half an LSB of the shifted result; the sum path only shifts when scaling.
    logic signed [PW-1:0] rnd_s, rnd_p;

    assign rnd_s = s2_scale ? PW'(1) : PW'(0);
    assign rnd_p = s2_scale ? PW'(1) << (DW - 1) : PW'(1) << (DW - 2);
    assign sr_r  = sr_x + rnd_s;
    assign si_r  = si_x + rnd_s;
    assign pr_r  = s2_pr + rnd_p;
    assign pi_r  = s2_pi + rnd_p;
`else
    assign sr_r = sr_x;
    assign si_r = si_x;
    assign pr_r = s2_pr;
    assign pi_r = s2_pi;
`endif

    assign sr_sh = s2_scale ? (sr_r >>> 1) : sr_r;
    assign si_sh = s2_scale ? (si_r >>> 1) : si_r;
    assign pr_sh = s2_scale ? (pr_r >>> DW) : (pr_r >>> (DW - 1));
    assign pi_sh = s2_scale ? (pi_r >>> DW) : (pi_r >>> (DW - 1));

    // Returns {saturated, value}; the most negative code is never produced.
    function automatic logic [DW:0] saturate(input logic signed [PW-1:0] x);
        logic signed [PW-1:0] maxv, minv;
        maxv = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        minv = -maxv;
        if (x > maxv) begin
            saturate = {1'b1, maxv[DW-1:0]};
        end else if (x < minv) begin
            saturate = {1'b1, minv[DW-1:0]};
        end else begin
            saturate = {1'b0, x[DW-1:0]};
        end
    endfunction

    logic [DW:0] q_ar, q_ai, q_br, q_bi;
    logic        any_sat;

    assign q_ar    = saturate(sr_sh);
    assign q_ai    = saturate(si_sh);
    assign q_br    = saturate(pr_sh);
    assign q_bi    = saturate(pi_sh);
    assign any_sat = q_ar[DW] | q_ai[DW] | q_br[DW] | q_bi[DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_last  <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (en3) begin
                out_valid <= v2;
                if (v2) begin
                    out_a    <= {q_ar[DW-1:0], q_ai[DW-1:0]};
                    out_b    <= {q_br[DW-1:0], q_bi[DW-1:0]};
                    out_last <= s2_last;
                end
            end
            // a saturated load beats a simultaneous clear
            if (en3 && v2 && any_sat) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule
